// File: rtl/radix2_butterfly_pipe_if.sv
// Operand/result bus between the FFT stage sequencer (master) and the
// radix2_butterfly_pipe datapath (slave).
interface radix2_butterfly_pipe_if #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16,
    parameter int ADDR_W = 9,
    parameter int CTRL_W = 2
);
    logic                     iact;
    logic [CTRL_W-1:0]        ictrl;
    logic                     iscale;
    logic [ADDR_W-1:0]        input_memory_address;
    logic signed [DATA_W-1:0] A_real;
    logic signed [DATA_W-1:0] A_imag;
    logic signed [DATA_W-1:0] B_real;
    logic signed [DATA_W-1:0] B_imag;
    logic signed [TW_W-1:0]   twiddle_real;
    logic signed [TW_W-1:0]   twiddle_imag;
    logic                     clear_ovf;

    logic                     oact;
    logic [CTRL_W-1:0]        octrl;
    logic [ADDR_W-1:0]        output_memory_address;
    logic signed [DATA_W-1:0] out_A_real;
    logic signed [DATA_W-1:0] out_A_imag;
    logic signed [DATA_W-1:0] out_B_real;
    logic signed [DATA_W-1:0] out_B_imag;
    logic                     ovf;

    modport master (
        output iact, ictrl, iscale, input_memory_address,
               A_real, A_imag, B_real, B_imag,
               twiddle_real, twiddle_imag, clear_ovf,
        input  oact, octrl, output_memory_address,
               out_A_real, out_A_imag, out_B_real, out_B_imag, ovf
    );

    modport slave (
        input  iact, ictrl, iscale, input_memory_address,
               A_real, A_imag, B_real, B_imag,
               twiddle_real, twiddle_imag, clear_ovf,
        output oact, octrl, output_memory_address,
               out_A_real, out_A_imag, out_B_real, out_B_imag, ovf
    );
endinterface

// File: rtl/radix2_butterfly_pipe.sv
// Fully pipelined radix-2 complex butterfly (DIF or DIT by MODE) with sideband delay.
// Define BFLY_SAT_EN to saturate out-of-range results instead of wrapping them.
module radix2_butterfly_pipe #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16,
    parameter int ADDR_W = 9,
    parameter int CTRL_W = 2,
    parameter int MODE   = 0
) (
    input logic                   clk,
    input logic                   reset,
    radix2_butterfly_pipe_if.slave bfly
);

    localparam int EXT_W  = DATA_W + 1;
    localparam int PROD_W = DATA_W + TW_W + 1;
    localparam int SUM_W  = DATA_W + TW_W + 2;
    localparam int RND_W  = DATA_W + 3;
    localparam int WIDE_W = DATA_W + 4;

    localparam logic signed [SUM_W-1:0]  ROUND_HALF = {{(SUM_W-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
    localparam logic signed [WIDE_W-1:0] ONE_WIDE   = {{(WIDE_W-1){1'b0}}, 1'b1};
`ifdef BFLY_SAT_EN
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    if (MODE != 0 && MODE != 1) begin : gBadMode
        $error("radix2_butterfly_pipe: MODE must be 0 (DIF) or 1 (DIT)");
    end

    // Returns {out_of_range, narrowed value}; optional halving rounds half up.
    function automatic logic [DATA_W:0] scaleNarrow(input logic signed [WIDE_W-1:0] x,
                                                    input logic halve);
        logic signed [WIDE_W-1:0] s;
        logic                     inRange;
        logic [DATA_W-1:0]        v;
        s       = halve ? ((x + ONE_WIDE) >>> 1) : x;
        inRange = (s[WIDE_W-1:DATA_W-1] == '0) || (s[WIDE_W-1:DATA_W-1] == '1);
`ifdef BFLY_SAT_EN
        if (inRange)          v = s[DATA_W-1:0];
        else if (s[WIDE_W-1]) v = NEG_MAX;
        else                  v = POS_MAX;
`else
        v = s[DATA_W-1:0];
`endif
        return {~inRange, v};
    endfunction

    logic                     v0_q, v1_q, v2_q, v3_q;
    logic                     scale0_q, scale1_q, scale2_q, scale3_q;
    logic [CTRL_W-1:0]        ctrl0_q, ctrl1_q, ctrl2_q, ctrl3_q;
    logic [ADDR_W-1:0]        addr0_q, addr1_q, addr2_q, addr3_q;

    logic signed [DATA_W-1:0] ar0_q, ai0_q, br0_q, bi0_q;
    logic signed [TW_W-1:0]   wr0_q, wi0_q, wr1_q, wi1_q;
    logic signed [EXT_W-1:0]  pr1_d, pi1_d, qr1_d, qi1_d;
    logic signed [EXT_W-1:0]  pr1_q, pi1_q, qr1_q, qi1_q;
    logic signed [EXT_W-1:0]  pr2_q, pi2_q, pr3_q, pi3_q;
    logic signed [PROD_W-1:0] rr2_d, ii2_d, ri2_d, ir2_d;
    logic signed [PROD_W-1:0] rr2_q, ii2_q, ri2_q, ir2_q;
    logic signed [SUM_W-1:0]  reSum, imSum;
    logic signed [RND_W-1:0]  tr3_d, ti3_d, tr3_q, ti3_q;
    logic                     unusedRoundBits;

    logic signed [WIDE_W-1:0] ar4, ai4, br4, bi4;
    logic [DATA_W:0]          nAr, nAi, nBr, nBi;
    logic                     ovf_d;

    logic                     oact_q, ovf_q;
    logic [CTRL_W-1:0]        octrl_q;
    logic [ADDR_W-1:0]        oaddr_q;
    logic [DATA_W-1:0]        oar_q, oai_q, obr_q, obi_q;

    // S1 forms the pass-through path (A+B for DIF, A for DIT) and the multiplicand (A-B or B).
    always_comb begin
        if (MODE == 0) begin
            pr1_d = EXT_W'(ar0_q) + EXT_W'(br0_q);
            pi1_d = EXT_W'(ai0_q) + EXT_W'(bi0_q);
            qr1_d = EXT_W'(ar0_q) - EXT_W'(br0_q);
            qi1_d = EXT_W'(ai0_q) - EXT_W'(bi0_q);
        end else begin
            pr1_d = EXT_W'(ar0_q);
            pi1_d = EXT_W'(ai0_q);
            qr1_d = EXT_W'(br0_q);
            qi1_d = EXT_W'(bi0_q);
        end
    end

    // Products stay full width so a -1 twiddle cannot wrap.
    always_comb begin
        rr2_d = PROD_W'(qr1_q) * PROD_W'(wr1_q);
        ii2_d = PROD_W'(qi1_q) * PROD_W'(wi1_q);
        ri2_d = PROD_W'(qr1_q) * PROD_W'(wi1_q);
        ir2_d = PROD_W'(qi1_q) * PROD_W'(wr1_q);
    end

    always_comb begin
        reSum = SUM_W'(rr2_q) - SUM_W'(ii2_q) + ROUND_HALF;
        imSum = SUM_W'(ri2_q) + SUM_W'(ir2_q) + ROUND_HALF;
        tr3_d = reSum[TW_W-1 +: RND_W];
        ti3_d = imSum[TW_W-1 +: RND_W];
    end
    assign unusedRoundBits = ^{reSum[TW_W-2:0], imSum[TW_W-2:0]};

    always_comb begin
        if (MODE == 0) begin
            ar4 = WIDE_W'(pr3_q);
            ai4 = WIDE_W'(pi3_q);
            br4 = WIDE_W'(tr3_q);
            bi4 = WIDE_W'(ti3_q);
        end else begin
            ar4 = WIDE_W'(pr3_q) + WIDE_W'(tr3_q);
            ai4 = WIDE_W'(pi3_q) + WIDE_W'(ti3_q);
            br4 = WIDE_W'(pr3_q) - WIDE_W'(tr3_q);
            bi4 = WIDE_W'(pi3_q) - WIDE_W'(ti3_q);
        end
        nAr   = scaleNarrow(ar4, scale3_q);
        nAi   = scaleNarrow(ai4, scale3_q);
        nBr   = scaleNarrow(br4, scale3_q);
        nBi   = scaleNarrow(bi4, scale3_q);
        ovf_d = (v3_q & (nAr[DATA_W] | nAi[DATA_W] | nBr[DATA_W] | nBi[DATA_W]))
              | (ovf_q & ~bfly.clear_ovf);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            scale0_q <= 1'b0; scale1_q <= 1'b0; scale2_q <= 1'b0; scale3_q <= 1'b0;
            ctrl0_q <= '0; ctrl1_q <= '0; ctrl2_q <= '0; ctrl3_q <= '0;
            addr0_q <= '0; addr1_q <= '0; addr2_q <= '0; addr3_q <= '0;
            ar0_q <= '0; ai0_q <= '0; br0_q <= '0; bi0_q <= '0;
            wr0_q <= '0; wi0_q <= '0; wr1_q <= '0; wi1_q <= '0;
            pr1_q <= '0; pi1_q <= '0; qr1_q <= '0; qi1_q <= '0;
            pr2_q <= '0; pi2_q <= '0; pr3_q <= '0; pi3_q <= '0;
            rr2_q <= '0; ii2_q <= '0; ri2_q <= '0; ir2_q <= '0;
            tr3_q <= '0; ti3_q <= '0;
        end else begin
            v0_q     <= bfly.iact;
            scale0_q <= bfly.iscale;
            ctrl0_q  <= bfly.ictrl;
            addr0_q  <= bfly.input_memory_address;
            ar0_q    <= bfly.A_real;
            ai0_q    <= bfly.A_imag;
            br0_q    <= bfly.B_real;
            bi0_q    <= bfly.B_imag;
            wr0_q    <= bfly.twiddle_real;
            wi0_q    <= bfly.twiddle_imag;

            v1_q <= v0_q; scale1_q <= scale0_q; ctrl1_q <= ctrl0_q; addr1_q <= addr0_q;
            pr1_q <= pr1_d; pi1_q <= pi1_d; qr1_q <= qr1_d; qi1_q <= qi1_d;
            wr1_q <= wr0_q; wi1_q <= wi0_q;

            v2_q <= v1_q; scale2_q <= scale1_q; ctrl2_q <= ctrl1_q; addr2_q <= addr1_q;
            pr2_q <= pr1_q; pi2_q <= pi1_q;
            rr2_q <= rr2_d; ii2_q <= ii2_d; ri2_q <= ri2_d; ir2_q <= ir2_d;

            v3_q <= v2_q; scale3_q <= scale2_q; ctrl3_q <= ctrl2_q; addr3_q <= addr2_q;
            pr3_q <= pr2_q; pi3_q <= pi2_q;
            tr3_q <= tr3_d; ti3_q <= ti3_d;
        end
    end

    // Result registers only load on a valid transaction so they hold between results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oact_q  <= 1'b0;
            ovf_q   <= 1'b0;
            octrl_q <= '0;
            oaddr_q <= '0;
            oar_q   <= '0;
            oai_q   <= '0;
            obr_q   <= '0;
            obi_q   <= '0;
        end else begin
            oact_q <= v3_q;
            ovf_q  <= ovf_d;
            if (v3_q) begin
                octrl_q <= ctrl3_q;
                oaddr_q <= addr3_q;
                oar_q   <= nAr[DATA_W-1:0];
                oai_q   <= nAi[DATA_W-1:0];
                obr_q   <= nBr[DATA_W-1:0];
                obi_q   <= nBi[DATA_W-1:0];
            end
        end
    end

    assign bfly.oact                  = oact_q;
    assign bfly.ovf                   = ovf_q;
    assign bfly.octrl                 = octrl_q;
    assign bfly.output_memory_address = oaddr_q;
    assign bfly.out_A_real            = oar_q;
    assign bfly.out_A_imag            = oai_q;
    assign bfly.out_B_real            = obr_q;
    assign bfly.out_B_imag            = obi_q;

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Directed bench for radix2_butterfly_pipe: one DIF and one DIT instance share stimulus.
module tb_radix2_butterfly_pipe;

    localparam int DATA_W = 16;
    localparam int TW_W   = 16;
    localparam int ADDR_W = 9;
    localparam int CTRL_W = 2;

`ifdef BFLY_SAT_EN
    localparam int OVF_A_REAL = 32767;
`else
    localparam int OVF_A_REAL = -32768;
`endif

    logic clk = 1'b0;
    logic reset;
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    radix2_butterfly_pipe_if #(.DATA_W(DATA_W), .TW_W(TW_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) difBus ();
    radix2_butterfly_pipe_if #(.DATA_W(DATA_W), .TW_W(TW_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) ditBus ();

    radix2_butterfly_pipe #(.DATA_W(DATA_W), .TW_W(TW_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .MODE(0)) dutDif (
        .clk   (clk),
        .reset (reset),
        .bfly  (difBus)
    );

    radix2_butterfly_pipe #(.DATA_W(DATA_W), .TW_W(TW_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .MODE(1)) dutDit (
        .clk   (clk),
        .reset (reset),
        .bfly  (ditBus)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic act, input int ctrl, input logic sc, input int addr,
                                 input int ar, input int ai, input int br, input int bi,
                                 input int wr, input int wi);
        difBus.iact                 = act;
        difBus.ictrl                = ctrl[CTRL_W-1:0];
        difBus.iscale               = sc;
        difBus.input_memory_address = addr[ADDR_W-1:0];
        difBus.A_real               = ar[DATA_W-1:0];
        difBus.A_imag               = ai[DATA_W-1:0];
        difBus.B_real               = br[DATA_W-1:0];
        difBus.B_imag               = bi[DATA_W-1:0];
        difBus.twiddle_real         = wr[TW_W-1:0];
        difBus.twiddle_imag         = wi[TW_W-1:0];
        ditBus.iact                 = act;
        ditBus.ictrl                = ctrl[CTRL_W-1:0];
        ditBus.iscale               = sc;
        ditBus.input_memory_address = addr[ADDR_W-1:0];
        ditBus.A_real               = ar[DATA_W-1:0];
        ditBus.A_imag               = ai[DATA_W-1:0];
        ditBus.B_real               = br[DATA_W-1:0];
        ditBus.B_imag               = bi[DATA_W-1:0];
        ditBus.twiddle_real         = wr[TW_W-1:0];
        ditBus.twiddle_imag         = wi[TW_W-1:0];
    endtask

    task automatic setClear(input logic c);
        difBus.clear_ovf = c;
        ditBus.clear_ovf = c;
    endtask

    // Drives one transaction before edge N and returns at the negedge after edge N+4.
    task automatic runOne(input int ctrl, input logic sc, input int addr,
                          input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi);
        applyStimulus(1'b1, ctrl, sc, addr, ar, ai, br, bi, wr, wi);
        @(negedge clk);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("latency.early", int'(difBus.oact), 0);
        @(negedge clk);
        checkOutput("latency.difOact", int'(difBus.oact), 1);
        checkOutput("latency.ditOact", int'(ditBus.oact), 1);
    endtask

    task automatic checkDif(input string tag, input int ar, input int ai, input int br, input int bi);
        checkOutput({tag, ".difAr"}, int'(difBus.out_A_real), ar);
        checkOutput({tag, ".difAi"}, int'(difBus.out_A_imag), ai);
        checkOutput({tag, ".difBr"}, int'(difBus.out_B_real), br);
        checkOutput({tag, ".difBi"}, int'(difBus.out_B_imag), bi);
    endtask

    task automatic checkDit(input string tag, input int ar, input int ai, input int br, input int bi);
        checkOutput({tag, ".ditAr"}, int'(ditBus.out_A_real), ar);
        checkOutput({tag, ".ditAi"}, int'(ditBus.out_A_imag), ai);
        checkOutput({tag, ".ditBr"}, int'(ditBus.out_B_real), br);
        checkOutput({tag, ".ditBi"}, int'(ditBus.out_B_imag), bi);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        setClear(1'b0);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset.oact", int'(difBus.oact), 0);
        checkOutput("reset.ovf", int'(difBus.ovf), 0);
        checkOutput("reset.addr", int'(difBus.output_memory_address), 0);
        checkDif("reset", 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] DIF/DIT with W = 1");
        runOne(2, 1'b0, 'h1A5, 100, 50, 20, 10, 32767, 0);
        checkDif("w1", 120, 60, 80, 40);
        checkDit("w1", 120, 60, 80, 40);
        checkOutput("w1.addr", int'(difBus.output_memory_address), 'h1A5);
        checkOutput("w1.octrl", int'(difBus.octrl), 2);
        checkOutput("w1.ovf", int'(difBus.ovf), 0);
        @(negedge clk);
        checkOutput("hold.oact", int'(difBus.oact), 0);
        checkOutput("hold.Ar", int'(difBus.out_A_real), 120);
        checkOutput("hold.addr", int'(difBus.output_memory_address), 'h1A5);

        $display("[TB] W = -j");
        runOne(1, 1'b0, 3, 100, 50, 20, 10, 0, -32768);
        checkDif("wj", 120, 60, 40, -80);
        checkDit("wj", 110, 30, 90, 70);
        runOne(1, 1'b0, 4, 100, 0, 20, 10, 0, -32768);
        checkDif("wj2", 120, 10, -10, -80);
        checkDit("wj2", 110, -20, 90, 20);

        $display("[TB] scaling");
        runOne(0, 1'b1, 5, 101, 0, 0, 0, 32767, 0);
        checkDif("scale", 51, 0, 51, 0);
        checkDit("scale", 51, 0, 51, 0);
        checkOutput("scale.ovf", int'(difBus.ovf), 0);

        $display("[TB] overflow");
        runOne(0, 1'b0, 6, 32767, 0, 1, 0, 32767, 0);
        checkDif("ovf", OVF_A_REAL, 0, 32765, 0);
        checkDit("ovf", OVF_A_REAL, 0, 32766, 0);
        checkOutput("ovf.difFlag", int'(difBus.ovf), 1);
        checkOutput("ovf.ditFlag", int'(ditBus.ovf), 1);
        runOne(0, 1'b0, 7, 100, 50, 20, 10, 32767, 0);
        checkOutput("ovf.sticky", int'(difBus.ovf), 1);
        setClear(1'b1);
        @(negedge clk);
        setClear(1'b0);
        checkOutput("ovf.cleared", int'(difBus.ovf), 0);

        // Clear lands on the same edge as a fresh overflow result; the set must win.
        applyStimulus(1'b1, 0, 1'b0, 8, 32767, 0, 1, 0, 32767, 0);
        @(negedge clk);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        setClear(1'b1);
        @(negedge clk);
        setClear(1'b0);
        checkOutput("ovf.setWinsOact", int'(difBus.oact), 1);
        checkOutput("ovf.setWins", int'(difBus.ovf), 1);
        @(negedge clk);

        $display("[TB] back-to-back stream");
        for (int c = 0; c < 14; c++) begin
            checkOutput("b2b.oact", int'(difBus.oact), (c >= 5 && c <= 12) ? 1 : 0);
            if (c >= 5 && c <= 12) begin
                checkOutput("b2b.addr", int'(difBus.output_memory_address), c - 5);
                checkOutput("b2b.octrl", int'(difBus.octrl), (c - 5) % 4);
            end
            if (c < 8) applyStimulus(1'b1, c % 4, 1'b0, c, 0, 0, 0, 0, 32767, 0);
            else       applyStimulus(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end

        $display("[TB] reset with transactions in flight");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, k, 1'b0, k + 1, 32767, 0, 1, 0, 32767, 0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        checkOutput("rst.asyncAddr", int'(difBus.output_memory_address), 0);
        checkOutput("rst.asyncOctrl", int'(difBus.octrl), 0);
        checkOutput("rst.asyncOvf", int'(difBus.ovf), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rst.noOact", int'(difBus.oact), 0);
        end
        checkOutput("rst.ovf", int'(difBus.ovf), 0);
        checkOutput("rst.ditOact", int'(ditBus.oact), 0);
        checkDif("rst", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/radix2_butterfly_pipe.md
Name: radix2_butterfly_pipe

Overview:
- Parametrised, fully pipelined radix-2 complex butterfly; successor to the single-mode FFT butterfly.
- Accepts one butterfly per cycle, supports DIF or DIT ordering and per-transaction 1/2 scaling, and has a sticky overflow flag.
- Carries control and memory-address sideband alongside the data with a fixed latency.
- Sits between the FFT stage sequencer (operand/twiddle fetch) and the result write-back memory.

Parameters:
- DATA_W, 16, width of each real/imag data component (two's complement).
- TW_W, 16, twiddle component width, Q1.(TW_W-1) format.
- ADDR_W, 9, memory address sideband width.
- CTRL_W, 2, control sideband width.
- MODE, 0, 0 = DIF (A'=A+B, B'=(A-B)W); 1 = DIT (A'=A+WB, B'=A-WB).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iact  in  1  input transaction valid.
- ictrl  in  CTRL_W  control sideband, delayed to octrl.
- iscale  in  1  1 = divide both outputs by 2 for this transaction.
- input_memory_address  in  ADDR_W  address sideband, delayed to output_memory_address.
- A_real, A_imag, B_real, B_imag  in  DATA_W  operands, signed.
- twiddle_real, twiddle_imag  in  TW_W  twiddle factor, signed.
- clear_ovf  in  1  synchronous clear of ovf.
- oact  out  1  output valid, one cycle per transaction.
- octrl  out  CTRL_W  delayed ictrl.
- output_memory_address  out  ADDR_W  delayed address.
- out_A_real, out_A_imag, out_B_real, out_B_imag  out  DATA_W  results, signed.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (reset=0, async): all pipeline valids, data outputs, octrl, output_memory_address and ovf go to 0. In-flight transactions are discarded; nothing stale emerges after release.
- Latency: exactly 4 cycles. iact sampled high at edge N gives oact=1 in the cycle after edge N+4. Throughput 1 per cycle, no backpressure, no bubbles inserted.
- Sideband (ictrl, iscale, address) travels with its data; outputs hold their last value while oact=0.
- DIF pipeline:
  - S1: sum = A+B, diff = A-B at DATA_W+1 bits.
  - S2: four products diff x W at full width.
  - S3: re = rr - ii, im = ri + ir; round by adding 2^(TW_W-2), then arithmetic shift right by TW_W-1.
  - S4: scale and clamp.
  - The sum path is delay-matched to the product path.
- DIT pipeline:
  - S1: register operands.
  - S2: products B x W.
  - S3: t = round-shift as above.
  - S4: A+t and A-t, then scale and clamp.
- Scaling: iscale=1 computes (x+1)>>>1 on the widened value (round half up); iscale=0 passes the value through.
- Narrowing to DATA_W: a value outside the signed DATA_W range sets ovf=1 if that transaction's oact is high. Output behaviour depends on the optional feature.
- ovf is sticky until clear_ovf=1 or reset. If clear_ovf and a new overflow occur in the same cycle, ovf=1 (set wins).
- Twiddle -1 (most-negative value) is legal; its product keeps full width internally, so intermediate values never wrap.
- MODE is elaborate-time only; any other value is an elaboration error.

Optional Feature:
- Macro BFLY_SAT_EN.
- Defined: out-of-range results saturate to +(2^(DATA_W-1)-1) or -2^(DATA_W-1); ovf still sets.
- Undefined: out-of-range results wrap (keep the low DATA_W bits); ovf still sets.

Test Plan:
- DIF, A=100+j50, B=20+j10, W=32767+j0, iscale=0 -> oact 4 cycles later, out_A=120+j60, out_B=80+j40, ovf=0.
- DIF, same A/B, W=0-j32768 -> out_B=40-j80. DIT, A=100+j0, B=20+j10, W=0-j32768 -> out_A=110-j20, out_B=90+j20.
- DIF, A=101+j0, B=0, W=32767, iscale=1 -> out_A=51+j0, out_B=51+j0.
- A_real=32767, B_real=1, imag 0, iscale=0:
  - without BFLY_SAT_EN, out_A_real=-32768 and ovf=1;
  - with BFLY_SAT_EN, out_A_real=32767 and ovf=1;
  - clear_ovf pulse -> ovf=0 next cycle.
- 8 back-to-back iact with addresses 0..7 and ictrl cycling 0..3 -> 8 consecutive oact cycles starting 4 cycles later, addresses 0..7 in order, octrl matching.
- Assert reset with 3 transactions in flight, release after 2 cycles -> all outputs 0, no oact pulse afterwards until new iact.
